disp_spi_master: RTL and testbench
==================================

# disp_spi_master

SPI master that sends 16-bit register-write frames to the Nexys4 display peripheral. It accepts an address/value pair over a valid/ready handshake and serialises `{CMD, addr[3:0], data[7:0]}` MSB-first on MOSI, using an idle-high SCLK in which the slave samples on the rising edge. During each frame it captures MISO into a 16-bit readback word. It sits between the soft-core's peripheral bus glue and the display's SPI pins.

## Interface
Parameters:
- `CLK_DIV`, 2: SCLK half-period in `clock_5meg_i` cycles; legal range ≥1.
- `HOLD_CYCLES`, 4: post-frame cycles with SS high and SCLK high; legal range ≥2.
- `CMD`, 4'b0001: command nibble placed in frame[15:12].

Ports:
- `clock_5meg_i` in 1: 5 MHz system clock; the only clock.
- `rst_low_i` in 1: reset, asynchronous, active-low.
- `wr_valid_i` in 1: write request.
- `wr_ready_o` out 1: high only in IDLE.
- `wr_addr_i` in 4: register address, copied into frame[11:8].
- `wr_data_i` in 8: register value, copied into frame[7:0].
- `done_o` out 1: one-cycle pulse when a transaction completes.
- `rx_data_o` out 16: MISO bits captured during the last frame, first bit in [15].
- `spi_sclk_o` out 1: serial clock, idle high.
- `spi_ss_o` out 1: slave select, active-low, idle high.
- `spi_mosi_o` out 1: serial data, idle high.
- `spi_miso_i` in 1: serial data from the slave.

## Operation
- All outputs are registered. Reset values: `spi_sclk_o`=1, `spi_ss_o`=1, `spi_mosi_o`=1, `done_o`=0, `rx_data_o`=0, `wr_ready_o`=1, state=IDLE.
- A request is accepted on a clock edge where `wr_valid_i` and `wr_ready_o` are both high. Inputs are latched into the frame register. `wr_valid_i` is ignored whenever `wr_ready_o` is low.
- State machine:
  - **IDLE**: SS, SCLK and MOSI are high. On accept, go to SETUP.
  - **SETUP**: lasts CLK_DIV cycles. SS=0, SCLK=1, MOSI=frame[15].
  - **SHIFT**: 16 bits, indexed i=0..15. Each bit has a low phase (SCLK=0, CLK_DIV cycles) followed by a high phase (SCLK=1, CLK_DIV cycles). MOSI=frame[15-i] and changes only on the edge that drives SCLK low. On the edge that drives SCLK high, MISO is sampled into the receive shifter. A 5-bit bit counter is used. After the high phase of bit 15, go to HOLD.
  - **HOLD**: lasts HOLD_CYCLES cycles. SS=1, SCLK=1, MOSI=1. On exit, go to FLUSH if it is compiled in (see Configuration); otherwise go to IDLE.
  - **FLUSH**: SS=1, MOSI=1. SCLK is low for CLK_DIV cycles, then high for CLK_DIV cycles. Then go to IDLE.
- On entry to IDLE after a transaction:
  - `done_o`=1 for exactly one cycle.
  - `rx_data_o` is loaded from the receive shifter in the same cycle.
  - `rx_data_o` is otherwise held.
- Address 4'hF is sent unmodified; the slave treats it as a no-op.

## Timing
- Number cycles from 1, where cycle 1 is the first SETUP cycle, immediately after the accept edge.
- `done_o` is high in cycle N = CLK_DIV + 32·CLK_DIV + HOLD_CYCLES + F + 1, where F = 2·CLK_DIV with FLUSH and 0 without.
  - With defaults: N=75 with FLUSH, N=71 without.
- `wr_ready_o` is high in the `done_o` cycle, so a new request can be accepted on that edge.
  - Back-to-back frames are therefore separated by ≥HOLD_CYCLES+1 cycles with SS high.
- SS goes low exactly CLK_DIV cycles before the first SCLK fall. SS goes high on the same edge as the 16th SCLK high phase ends.
- MOSI is stable for ≥CLK_DIV cycles around every SCLK rising edge.
- If `rst_low_i` is asserted mid-frame, all outputs go immediately to their reset values. The frame is discarded, `done_o` is not pulsed and `rx_data_o` is cleared.

## Configuration
- `DISP_SPI_FLUSH_PULSE_EN` defined: FLUSH is compiled in. Every transaction ends with one extra SCLK pulse (one falling edge, then one rising edge) while SS=1, which clears the slave's bit counter.
- Not defined: FLUSH is removed and HOLD goes directly to IDLE. Exactly 16 SCLK rising edges occur per transaction.

## Test plan
All scenarios use default parameters with the macro defined, unless noted.
- **Reset**: hold `rst_low_i`=0 → SCLK, SS and MOSI are 1; `done_o`=0; `rx_data_o`=0; `wr_ready_o`=1.
- **Single write**: addr=4'h3, data=8'hA5 → MOSI sampled at the 16 SS-low SCLK rises = 16'h13A5, MSB first; `done_o` in cycle 75; `wr_ready_o` low in cycles 1–74.
- **Readback**: slave drives MISO pattern 16'hC35A, aligned to the rises → `rx_data_o`=16'hC35A in the `done_o` cycle.
- **Back-to-back**: `wr_valid_i` held with (2,8'h01), then (5,8'hFF) → second accept on the `done_o` edge of the first; frames 16'h1201 and 16'h15FF; SS high between them for ≥5 cycles.
- **Reset mid-frame**: assert reset after the 7th SCLK rise → all pins return to idle on the same edge; no `done_o`; the next write (1,8'h3C) completes correctly.
- **Macro**:
  - Defined: 17 SCLK rises per transaction, the 17th with SS=1.
  - Undefined: 16 rises and `done_o` in cycle 71.

Source files
------------

// File: rtl/disp_spi_master.sv
// SPI master for the Nexys4 display: serialises {CMD, addr, data} MSB-first and captures MISO.
// Optional trailing SCLK pulse with SS high is enabled by defining DISP_SPI_FLUSH_PULSE_EN.
module disp_spi_master #(
    parameter int unsigned CLK_DIV     = 2,
    parameter int unsigned HOLD_CYCLES = 4,
    parameter logic [3:0]  CMD         = 4'b0001
) (
    input  logic        clock_5meg_i,
    input  logic        rst_low_i,
    input  logic        wr_valid_i,
    output logic        wr_ready_o,
    input  logic [3:0]  wr_addr_i,
    input  logic [7:0]  wr_data_i,
    output logic        done_o,
    output logic [15:0] rx_data_o,
    output logic        spi_sclk_o,
    output logic        spi_ss_o,
    output logic        spi_mosi_o,
    input  logic        spi_miso_i
);

    localparam int unsigned CNT_MAX = (CLK_DIV > HOLD_CYCLES) ? CLK_DIV : HOLD_CYCLES;
    localparam int unsigned CW      = $clog2(CNT_MAX);
    localparam logic [CW-1:0] DIV_LOAD  = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);

    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_SHIFT, S_HOLD, S_FLUSH} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [4:0]    bit_q, bit_d;
    logic          high_q, high_d;
    logic [15:0]   frame_q, frame_d;
    logic [15:0]   rxsh_q, rxsh_d;
    logic          sclk_q, sclk_d;
    logic          ss_q, ss_d;
    logic          mosi_q, mosi_d;
    logic          done_q, done_d;
    logic [15:0]   rx_q, rx_d;
    logic          ready_q, ready_d;

    always_ff @(posedge clock_5meg_i or negedge rst_low_i) begin
        if (!rst_low_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            high_q  <= 1'b0;
            frame_q <= '0;
            rxsh_q  <= '0;
            sclk_q  <= 1'b1;
            ss_q    <= 1'b1;
            mosi_q  <= 1'b1;
            done_q  <= 1'b0;
            rx_q    <= '0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            high_q  <= high_d;
            frame_q <= frame_d;
            rxsh_q  <= rxsh_d;
            sclk_q  <= sclk_d;
            ss_q    <= ss_d;
            mosi_q  <= mosi_d;
            done_q  <= done_d;
            rx_q    <= rx_d;
            ready_q <= ready_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        high_d  = high_q;
        frame_d = frame_q;
        rxsh_d  = rxsh_q;
        case (state_q)
            S_IDLE: begin
                if (wr_valid_i && ready_q) begin
                    frame_d = {CMD, wr_addr_i, wr_data_i};
                    cnt_d   = DIV_LOAD;
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    state_d = S_SHIFT;
                    cnt_d   = DIV_LOAD;
                    bit_d   = '0;
                    high_d  = 1'b0;
                end
            end
            // The frame shifts on entry to each low phase so frame_q[15] is always the bit on the wire.
            S_SHIFT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else if (!high_q) begin
                    high_d = 1'b1;
                    cnt_d  = DIV_LOAD;
                    rxsh_d = {rxsh_q[14:0], spi_miso_i};
                end else if (bit_q == 5'd15) begin
                    state_d = S_HOLD;
                    cnt_d   = HOLD_LOAD;
                end else begin
                    bit_d   = bit_q + 5'd1;
                    high_d  = 1'b0;
                    cnt_d   = DIV_LOAD;
                    frame_d = {frame_q[14:0], 1'b1};
                end
            end
            S_HOLD: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
`ifdef DISP_SPI_FLUSH_PULSE_EN
                    state_d = S_FLUSH;
                    cnt_d   = DIV_LOAD;
                    high_d  = 1'b0;
`else
                    state_d = S_IDLE;
`endif
                end
            end
`ifdef DISP_SPI_FLUSH_PULSE_EN
            S_FLUSH: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else if (!high_q) begin
                    high_d = 1'b1;
                    cnt_d  = DIV_LOAD;
                end else begin
                    state_d = S_IDLE;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so the pins are registered alongside it.
    always_comb begin
        ready_d = (state_d == S_IDLE);
        done_d  = (state_d == S_IDLE) && (state_q != S_IDLE);
        rx_d    = done_d ? rxsh_q : rx_q;
        ss_d    = !((state_d == S_SETUP) || (state_d == S_SHIFT));
        sclk_d  = 1'b1;
        if ((state_d == S_SHIFT) || (state_d == S_FLUSH)) begin
            sclk_d = high_d;
        end
        mosi_d  = ss_d ? 1'b1 : frame_d[15];
    end

    assign wr_ready_o = ready_q;
    assign done_o     = done_q;
    assign rx_data_o  = rx_q;
    assign spi_sclk_o = sclk_q;
    assign spi_ss_o   = ss_q;
    assign spi_mosi_o = mosi_q;

endmodule

// File: tb/tb_disp_spi_master.sv
// Directed bench for disp_spi_master: acts as the SPI slave and checks frames, timing and readback.
module tb_disp_spi_master;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_valid;
    logic        wr_ready;
    logic [3:0]  wr_addr;
    logic [7:0]  wr_data;
    logic        done;
    logic [15:0] rx_data;
    logic        sclk;
    logic        ss;
    logic        mosi;
    logic        miso;

    int total = 0;
    int bad   = 0;
    int ss_tail = 0;

`ifdef DISP_SPI_FLUSH_PULSE_EN
    localparam int DONE_CYC = 75;
    localparam int RISES    = 17;
    localparam int SS_GAP   = 9;
`else
    localparam int DONE_CYC = 71;
    localparam int RISES    = 16;
    localparam int SS_GAP   = 5;
`endif

    always #5 clk = ~clk;

    disp_spi_master #(
        .CLK_DIV     (2),
        .HOLD_CYCLES (4),
        .CMD         (4'b0001)
    ) dut (
        .clock_5meg_i (clk),
        .rst_low_i    (rst_n),
        .wr_valid_i   (wr_valid),
        .wr_ready_o   (wr_ready),
        .wr_addr_i    (wr_addr),
        .wr_data_i    (wr_data),
        .done_o       (done),
        .rx_data_o    (rx_data),
        .spi_sclk_o   (sclk),
        .spi_ss_o     (ss),
        .spi_mosi_o   (mosi),
        .spi_miso_i   (miso)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Called with the request already driven; its first negedge is cycle 1 after the accept edge.
    task automatic run_frame(input string tag, input logic [15:0] exp_frame, input logic [15:0] pat,
                             input bit keep_valid, input logic [3:0] na, input logic [7:0] nd);
        int          cyc       = 0;
        int          lo        = 0;
        int          hi        = 0;
        int          ready_bad = 0;
        int          done_cyc  = 0;
        logic        prev      = 1'b1;
        logic [15:0] got       = '0;
        logic [15:0] rx_seen   = '0;
        logic [15:0] pv;
        while (done_cyc == 0 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1 && !keep_valid) wr_valid = 1'b0;
            if (sclk && !prev) begin
                if (!ss) begin
                    got = {got[14:0], mosi};
                    lo++;
                end else begin
                    hi++;
                end
            end
            prev = sclk;
            if (ss) ss_tail++;
            else    ss_tail = 0;
            pv   = pat << lo;
            miso = (lo < 16) ? pv[15] : 1'b1;
            if (done) begin
                done_cyc = cyc;
                rx_seen  = rx_data;
                if (keep_valid) begin
                    wr_addr = na;
                    wr_data = nd;
                end
            end else if (wr_ready) begin
                ready_bad++;
            end
        end
        check({tag, "_frame"},     32'(got),      32'(exp_frame));
        check({tag, "_done_cyc"},  done_cyc,      DONE_CYC);
        check({tag, "_ready_low"}, ready_bad,     0);
        check({tag, "_ss_rises"},  lo,            16);
        check({tag, "_rises"},     lo + hi,       RISES);
        check({tag, "_rx"},        32'(rx_seen),  32'(pat));
    endtask

    initial begin
        int lo;
        int n;
        int dones;
        logic prev;

        rst_n    = 1'b0;
        wr_valid = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        miso     = 1'b1;

        repeat (3) @(negedge clk);
        check("rst_sclk",  32'(sclk),     1);
        check("rst_ss",    32'(ss),       1);
        check("rst_mosi",  32'(mosi),     1);
        check("rst_done",  32'(done),     0);
        check("rst_rx",    32'(rx_data),  0);
        check("rst_ready", 32'(wr_ready), 1);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single write with readback pattern
        wr_addr = 4'h3; wr_data = 8'hA5; wr_valid = 1'b1;
        run_frame("single", 16'h13A5, 16'hC35A, 1'b0, 4'h0, 8'h00);
        @(negedge clk);
        check("single_done_width", 32'(done), 0);
        repeat (5) @(negedge clk);
        check("single_rx_hold", 32'(rx_data), 32'hC35A);

        // No-op address goes out untouched
        wr_addr = 4'hF; wr_data = 8'h00; wr_valid = 1'b1;
        run_frame("addrF", 16'h1F00, 16'h0001, 1'b0, 4'h0, 8'h00);
        repeat (3) @(negedge clk);

        // Back-to-back with valid held throughout
        wr_addr = 4'h2; wr_data = 8'h01; wr_valid = 1'b1;
        run_frame("b2b1", 16'h1201, 16'h5A5A, 1'b1, 4'h5, 8'hFF);
        check("b2b_gap", ss_tail, SS_GAP);
        run_frame("b2b2", 16'h15FF, 16'hA55A, 1'b0, 4'h0, 8'h00);
        repeat (3) @(negedge clk);

        // Reset in the middle of a frame, after the 7th SCLK rise
        wr_addr = 4'h7; wr_data = 8'h42; wr_valid = 1'b1;
        lo = 0; n = 0; dones = 0; prev = 1'b1;
        while (lo < 7 && n < 200) begin
            @(negedge clk);
            n++;
            wr_valid = 1'b0;
            if (sclk && !prev && !ss) lo++;
            prev = sclk;
            if (done) dones++;
        end
        check("mid_reached", lo, 7);
        #2 rst_n = 1'b0;
        #1;
        check("mid_sclk",  32'(sclk),     1);
        check("mid_ss",    32'(ss),       1);
        check("mid_mosi",  32'(mosi),     1);
        check("mid_done",  32'(done),     0);
        check("mid_rx",    32'(rx_data),  0);
        check("mid_ready", 32'(wr_ready), 1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (done) dones++;
        end
        check("mid_no_done", dones, 0);
        check("mid_rx_hold", 32'(rx_data), 0);

        wr_addr = 4'h1; wr_data = 8'h3C; wr_valid = 1'b1;
        run_frame("after_rst", 16'h113C, 16'h8001, 1'b0, 4'h0, 8'h00);
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
